pulse_blinker: RTL and testbench

Converts single-cycle logic events into human-visible LED blinks: each `pulse_in` produces exactly one blink of fixed on-time, followed by a guaranteed dark gap. Events that arrive while a blink is in progress are counted and replayed in order. It sits on the output side of the board-level UI, driving LEDs from one-cycle strobes.

---
 rtl/pulse_blinker.sv | 170 +++++++++++++++++
 tb/tb_pulse_blinker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pulse_blinker.sv
// pulse_blinker: turns one-cycle event strobes into human-visible LED blinks.
// Each event produces one blink of ON_CYCLES cycles followed by at least
// OFF_CYCLES dark cycles. Events arriving mid-blink are counted in a
// saturating pending counter and replayed back-to-back.
//
// Optional build macro: PULSE_BLINKER_COALESCE_EN
//   defined   -> events while the LED is lit are ignored; only events
//                during the dark gap are queued.
//   undefined -> every event during ON or OFF is queued (default).

module pulse_blinker #(
    parameter int unsigned ON_CYCLES  = 5_000_000,
    parameter int unsigned OFF_CYCLES = 5_000_000,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_in,
    output logic              led_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0]     ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0]     OFF_LOAD = CW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_next_cnt;
    logic [PEND_W-1:0]   r_pending;
    logic [PEND_W-1:0]   w_next_pending;
    logic                r_overflow;
    logic                w_next_overflow;
    logic                r_led;
    logic                r_busy;

    logic                w_cnt_zero;
    logic                w_pend_nz;
    logic                w_off_end;
    logic                w_dequeue;
    logic                w_enqueue;
    logic                w_on_accept;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_pend_nz  = (r_pending != '0);
    assign w_off_end  = (r_state == ST_OFF) && w_cnt_zero;
    assign w_dequeue  = w_off_end && w_pend_nz;

`ifdef PULSE_BLINKER_COALESCE_EN
    assign w_on_accept = 1'b0;
`else
    assign w_on_accept = 1'b1;
`endif

    // An event at the very end of the dark gap with nothing queued starts
    // the next blink directly instead of passing through the counter, so it
    // is excluded from the enqueue term.
    always_comb begin
        w_enqueue = 1'b0;
        if (pulse_in) begin
            case (r_state)
                ST_ON:   w_enqueue = w_on_accept;
                ST_OFF:  w_enqueue = !(w_cnt_zero && !w_pend_nz);
                default: w_enqueue = 1'b0;
            endcase
        end
    end

    // Next-state and blink-timer logic
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (pulse_in) begin
                    w_next_state = ST_ON;
                    w_next_cnt   = ON_LOAD;
                end
            end
            ST_ON: begin
                if (w_cnt_zero) begin
                    w_next_state = ST_OFF;
                    w_next_cnt   = OFF_LOAD;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            ST_OFF: begin
                if (w_cnt_zero) begin
                    if (w_pend_nz || pulse_in) begin
                        w_next_state = ST_ON;
                        w_next_cnt   = ON_LOAD;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_cnt   = '0;
                    end
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Pending-count bookkeeping: an enqueue and a dequeue in the same cycle
    // cancel, so saturation can only drop an event when no dequeue occurs.
    always_comb begin
        w_next_pending  = r_pending;
        w_next_overflow = r_overflow;
        if (w_enqueue && w_dequeue) begin
            w_next_pending = r_pending;
        end else if (w_dequeue) begin
            w_next_pending = r_pending - 1'b1;
        end else if (w_enqueue) begin
            if (r_pending == PEND_MAX) begin
                w_next_overflow = 1'b1;
            end else begin
                w_next_pending = r_pending + 1'b1;
            end
        end
    end

    // State, timer and queue registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_pending  <= w_next_pending;
            r_overflow <= w_next_overflow;
        end
    end

    // Registered LED and busy drive, decoded from the next state so they
    // line up with the state register rather than lagging it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_led  <= (w_next_state == ST_ON);
            r_busy <= (w_next_state != ST_IDLE);
        end
    end

    assign led_out  = r_led;
    assign busy     = r_busy;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_pulse_blinker.sv
// Directed bench for pulse_blinker with ON_CYCLES=3, OFF_CYCLES=2, PEND_W=2.
// Each scenario is a set of per-cycle character strings: cycle c's pulse
// input and the expected led/busy/pending/overflow values in that cycle.

module tb_pulse_blinker;

    logic       clk;
    logic       rst;
    logic       pulse_in;
    logic       led_out;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int n_vec;
    int n_err;

    pulse_blinker #(
        .ON_CYCLES (3),
        .OFF_CYCLES(2),
        .PEND_W    (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pulse_in(pulse_in),
        .led_out (led_out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    function automatic int dig(input byte b);
        return int'(b) - 48;
    endfunction

    task automatic chk(input string tag, input int cyc, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Per cycle: drive pulse, check outputs of that cycle, advance one edge.
    task automatic run(input string tag, input string pul, input string led,
                       input string bsy, input string pnd, input string ovf);
        for (int c = 0; c < pul.len(); c++) begin
            pulse_in = (pul[c] == "1");
            chk({tag, ".led"},      c, int'(led_out),  dig(led[c]));
            chk({tag, ".busy"},     c, int'(busy),     dig(bsy[c]));
            chk({tag, ".pending"},  c, int'(pending),  dig(pnd[c]));
            chk({tag, ".overflow"}, c, int'(overflow), dig(ovf[c]));
            @(posedge clk);
            #1;
        end
        pulse_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        pulse_in = 1'b0;
        @(posedge clk);
        #1;
        chk("reset.led",      0, int'(led_out),  0);
        chk("reset.busy",     0, int'(busy),     0);
        chk("reset.pending",  0, int'(pending),  0);
        chk("reset.overflow", 0, int'(overflow), 0);
        rst = 1'b0;

        // Single pulse
        run("single", "10000000", "01110000", "01111100", "00000000", "00000000");

        // Three back-to-back pulses, replayed with period ON+OFF
        do_reset();
        run("burst3",
            "111000000000000000",
            "011100111001110000",
            "011111111111111100",
            "001222111110000000",
            "000000000000000000");

        // Five pulses saturate the 2-bit counter and drop one event
        do_reset();
        run("sat",
            "11111000000000000000000",
            "01110011100111001110000",
            "01111111111111111111100",
            "00123322222111110000000",
            "00000111111111111111111");

        // Pulse on the last dark cycle starts the next blink directly
        do_reset();
        run("lastoff", "1000010000", "0111001110", "0111111111", "0000000000", "0000000000");

        // Pulses at cycles 0, 1, 4
        do_reset();
`ifdef PULSE_BLINKER_COALESCE_EN
        run("p014",
            "11001000000000000",
            "01110011100000000",
            "01111111111000000",
            "00000100000000000",
            "00000000000000000");
`else
        run("p014",
            "11001000000000000",
            "01110011100111000",
            "01111111111111110",
            "00111211111000000",
            "00000000000000000");
`endif

        // Asynchronous reset mid-blink with pending=1 and overflow set
        do_reset();
        run("prerst",
            "111110000000",
            "011100111001",
            "011111111111",
            "001233222221",
            "000001111111");
        chk("prerst.led",      12, int'(led_out),  1);
        chk("prerst.pending",  12, int'(pending),  1);
        chk("prerst.overflow", 12, int'(overflow), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("asyncrst.led",      12, int'(led_out),  0);
        chk("asyncrst.busy",     12, int'(busy),     0);
        chk("asyncrst.pending",  12, int'(pending),  0);
        chk("asyncrst.overflow", 12, int'(overflow), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run("postrst", "10000000", "01110000", "01111100", "00000000", "00000000");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
